// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control decoder and its multiply/divide unit.
package alu_ctrl_pkg;

   // ALUop from main control
   localparam logic [2:0] ALUOP_ADD   = 3'b000;
   localparam logic [2:0] ALUOP_SUBU  = 3'b001;
   localparam logic [2:0] ALUOP_RTYPE = 3'b010;
   localparam logic [2:0] ALUOP_AND   = 3'b011;
   localparam logic [2:0] ALUOP_OR    = 3'b100;
   localparam logic [2:0] ALUOP_SLL   = 3'b101;
   localparam logic [2:0] ALUOP_SLTU  = 3'b110;
   localparam logic [2:0] ALUOP_SLT   = 3'b111;

   // R-type funct field
   localparam logic [5:0] F_AND   = 6'b100100;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_SLL   = 6'b000000;
   localparam logic [5:0] F_SRL   = 6'b000010;
   localparam logic [5:0] F_XOR   = 6'b100110;
   localparam logic [5:0] F_SUB   = 6'b100010;
   localparam logic [5:0] F_SLT   = 6'b101010;
   localparam logic [5:0] F_ADDU  = 6'b100001;
   localparam logic [5:0] F_SUBU  = 6'b100011;
   localparam logic [5:0] F_SLTU  = 6'b101011;
   localparam logic [5:0] F_NOR   = 6'b100111;
   localparam logic [5:0] F_SRA   = 6'b000011;
   localparam logic [5:0] F_SLLV  = 6'b000100;
   localparam logic [5:0] F_SRLV  = 6'b000110;
   localparam logic [5:0] F_SRAV  = 6'b000111;
   localparam logic [5:0] F_JR    = 6'b001000;
   localparam logic [5:0] F_JALR  = 6'b001001;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;

   // ALU operation codes
   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SLL  = 4'b0011;
   localparam logic [3:0] OP_SRL  = 4'b0100;
   localparam logic [3:0] OP_XOR  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_ADDU = 4'b1000;
   localparam logic [3:0] OP_SUBU = 4'b1001;
   localparam logic [3:0] OP_SLTU = 4'b1010;
   localparam logic [3:0] OP_NOR  = 4'b1011;
   localparam logic [3:0] OP_SRA  = 4'b1100;

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} mdu_state_e;

   // True for the HI/LO and multiply/divide funct codes
   function automatic logic is_mdu_funct(input logic [5:0] f);
      return (f[5:2] == 4'b0100) || (f[5:2] == 4'b0110);
   endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide datapath: shift-add multiply, restoring
// divide, and a final FIX cycle that applies sign correction.
module mdu_iter
   import alu_ctrl_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNTW  = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_mul,
   input  logic             start_div,
   input  logic             sgn,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] res_hi,
   output logic [WIDTH-1:0] res_lo
);

   mdu_state_e         state;
   logic [CNTW-1:0]    cnt;
   logic [WIDTH-1:0]   opa;      // multiplicand or divisor magnitude
   logic [2*WIDTH-1:0] acc;      // product, or {remainder, quotient}
   logic               is_div;
   logic               neg_lo;   // negate product / quotient
   logic               neg_hi;   // negate remainder

   logic [WIDTH-1:0]   ma, mb;
   logic               div0, ovf;
   logic [WIDTH:0]     msum, dshift, ddiff;
   logic [2*WIDTH-1:0] prod;

   // Operand magnitudes, special divide cases and one iteration step
   always_comb begin
      ma     = (sgn && a[WIDTH-1]) ? -a : a;
      mb     = (sgn && b[WIDTH-1]) ? -b : b;
      div0   = (b == '0);
      ovf    = sgn && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
      msum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opa} : '0);
      dshift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      ddiff  = dshift - {1'b0, opa};
   end

   // Control FSM with counter and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         busy   <= 1'b0;
         cnt    <= '0;
         opa    <= '0;
         acc    <= '0;
         is_div <= 1'b0;
         neg_lo <= 1'b0;
         neg_hi <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_mul) begin
                  opa    <= ma;
                  acc    <= {{WIDTH{1'b0}}, mb};
                  is_div <= 1'b0;
                  neg_lo <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_hi <= 1'b0;
                  cnt    <= CNTW'(WIDTH);
                  busy   <= 1'b1;
                  state  <= MUL;
               end else if (start_div) begin
                  is_div <= 1'b1;
                  busy   <= 1'b1;
                  // Special cases preload the final answer and skip iterating
                  if (div0) begin
                     acc    <= {a, {WIDTH{1'b1}}};
                     neg_lo <= 1'b0;
                     neg_hi <= 1'b0;
                     state  <= FIX;
                  end else if (ovf) begin
                     acc    <= {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
                     neg_lo <= 1'b0;
                     neg_hi <= 1'b0;
                     state  <= FIX;
                  end else begin
                     opa    <= mb;
                     acc    <= {{WIDTH{1'b0}}, ma};
                     neg_lo <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                     neg_hi <= sgn && a[WIDTH-1];
                     cnt    <= CNTW'(WIDTH);
                     state  <= DIV;
                  end
               end
            end
            MUL: begin
               acc <= {msum, acc[WIDTH-1:1]};
               cnt <= cnt - 1'b1;
               if (cnt == CNTW'(1)) state <= FIX;
            end
            DIV: begin
               if (!ddiff[WIDTH]) acc <= {ddiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
               else               acc <= {dshift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
               cnt <= cnt - 1'b1;
               if (cnt == CNTW'(1)) state <= FIX;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   // Sign-corrected result, presented during FIX
   always_comb begin
      done = (state == FIX);
      prod = neg_lo ? -acc : acc;
      if (is_div) begin
         res_hi = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
         res_lo = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      end else begin
         res_hi = prod[2*WIDTH-1:WIDTH];
         res_lo = prod[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/alu_ctrl_mdu.sv
// ALU control decoder with HI/LO registers and an iterative multiply/divide
// unit; stalls MDU-class instructions while the unit is busy.
module alu_ctrl_mdu
   import alu_ctrl_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int OPW   = 4,
   parameter int CNTW  = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [2:0]       alu_op,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   output logic [OPW-1:0]   operation,
   output logic             jump,
   output logic             link,
   output logic             mf_valid,
   output logic [WIDTH-1:0] mf_result,
   output logic             stall,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   logic             mdu_cls, acc_ok;
   logic             start_mul, start_div, sgn;
   logic             done;
   logic [WIDTH-1:0] res_hi, res_lo;

   // ALUop / funct decode
   always_comb begin
      operation = OPW'(OP_ADD);
      jump      = 1'b0;
      link      = 1'b0;
      case (alu_op)
         ALUOP_ADD:  operation = OPW'(OP_ADD);
         ALUOP_SUBU: operation = OPW'(OP_SUBU);
         ALUOP_AND:  operation = OPW'(OP_AND);
         ALUOP_OR:   operation = OPW'(OP_OR);
         ALUOP_SLL:  operation = OPW'(OP_SLL);
         ALUOP_SLTU: operation = OPW'(OP_SLTU);
         ALUOP_SLT:  operation = OPW'(OP_SLT);
         default: begin
            case (funct)
               F_AND:  operation = OPW'(OP_AND);
               F_OR:   operation = OPW'(OP_OR);
               F_SLL,
               F_SLLV: operation = OPW'(OP_SLL);
               F_SRL,
               F_SRLV: operation = OPW'(OP_SRL);
               F_XOR:  operation = OPW'(OP_XOR);
               F_SUB:  operation = OPW'(OP_SUB);
               F_SLT:  operation = OPW'(OP_SLT);
               F_ADDU: operation = OPW'(OP_ADDU);
               F_SUBU: operation = OPW'(OP_SUBU);
               F_SLTU: operation = OPW'(OP_SLTU);
               F_NOR:  operation = OPW'(OP_NOR);
               F_SRA,
               F_SRAV: operation = OPW'(OP_SRA);
               F_JR:   jump = 1'b1;
               F_JALR: begin
                  jump = 1'b1;
                  link = 1'b1;
               end
               default: operation = OPW'(OP_ADD);
            endcase
         end
      endcase
   end

   // Stall and accept for HI/LO and multiply/divide instructions
   always_comb begin
      mdu_cls   = in_valid && (alu_op == ALUOP_RTYPE) && is_mdu_funct(funct);
      stall     = mdu_cls && busy;
      acc_ok    = mdu_cls && !busy;
      mf_valid  = acc_ok && ((funct == F_MFHI) || (funct == F_MFLO));
      mf_result = (funct == F_MFHI) ? hi : lo;
      start_mul = acc_ok && ((funct == F_MULT) || (funct == F_MULTU));
      start_div = acc_ok && ((funct == F_DIV) || (funct == F_DIVU));
      sgn       = (funct == F_MULT) || (funct == F_DIV);
   end

   mdu_iter #(.WIDTH(WIDTH), .CNTW(CNTW)) u_mdu (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_mul (start_mul),
      .start_div (start_div),
      .sgn       (sgn),
      .a         (rs_val),
      .b         (rt_val),
      .busy      (busy),
      .done      (done),
      .res_hi    (res_hi),
      .res_lo    (res_lo)
   );

   // HI/LO writes; done and mt* are mutually exclusive since mt* stalls while busy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi <= '0;
         lo <= '0;
      end else if (done) begin
         hi <= res_hi;
         lo <= res_lo;
      end else if (acc_ok) begin
         if (funct == F_MTHI) hi <= rs_val;
         if (funct == F_MTLO) lo <= rs_val;
      end
   end

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Self-checking bench for alu_ctrl_mdu: behavioural reference model with a
// per-cycle compare process, plus directed vectors with literal results.
module tb_alu_ctrl_mdu;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic [2:0]   alu_op = 3'b000;
   logic [5:0]   funct = 6'b0;
   logic [W-1:0] rs_val = '0;
   logic [W-1:0] rt_val = '0;
   logic [3:0]   operation;
   logic         jump, link, mf_valid, stall, busy;
   logic [W-1:0] mf_result, hi, lo;

   int tests = 0;
   int fails = 0;

   alu_ctrl_mdu #(.WIDTH(W), .OPW(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .alu_op(alu_op),
      .funct(funct), .rs_val(rs_val), .rt_val(rt_val),
      .operation(operation), .jump(jump), .link(link),
      .mf_valid(mf_valid), .mf_result(mf_result), .stall(stall),
      .busy(busy), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference decode: {operation, jump, link}
   function automatic logic [5:0] exp_dec(input logic [2:0] ao, input logic [5:0] f);
      case (ao)
         3'b000: return {4'b0010, 2'b00};
         3'b001: return {4'b1001, 2'b00};
         3'b011: return {4'b0000, 2'b00};
         3'b100: return {4'b0001, 2'b00};
         3'b101: return {4'b0011, 2'b00};
         3'b110: return {4'b1010, 2'b00};
         3'b111: return {4'b0111, 2'b00};
         default: ;
      endcase
      case (f)
         6'h24: return {4'b0000, 2'b00};
         6'h25: return {4'b0001, 2'b00};
         6'h20: return {4'b0010, 2'b00};
         6'h00: return {4'b0011, 2'b00};
         6'h02: return {4'b0100, 2'b00};
         6'h26: return {4'b0101, 2'b00};
         6'h22: return {4'b0110, 2'b00};
         6'h2a: return {4'b0111, 2'b00};
         6'h21: return {4'b1000, 2'b00};
         6'h23: return {4'b1001, 2'b00};
         6'h2b: return {4'b1010, 2'b00};
         6'h27: return {4'b1011, 2'b00};
         6'h03: return {4'b1100, 2'b00};
         6'h04: return {4'b0011, 2'b00};
         6'h06: return {4'b0100, 2'b00};
         6'h07: return {4'b1100, 2'b00};
         6'h08: return {4'b0010, 2'b10};
         6'h09: return {4'b0010, 2'b11};
         default: return {4'b0010, 2'b00};
      endcase
   endfunction

   function automatic logic is_mdu(input logic [5:0] f);
      return (f inside {6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b});
   endfunction

   // Reference {HI,LO} from plain arithmetic
   function automatic logic [63:0] mdu_ref(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      int     q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (f)
         6'h18: return 64'(sa * sb);
         6'h19: return {32'b0, a} * {32'b0, b};
         6'h1b: if (b == 0) return {a, 32'hFFFFFFFF};
                else return {a % b, a / b};
         default: begin
            if (b == 0) return {a, 32'hFFFFFFFF};
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
            q = int'(sa / sb);
            r = int'(sa % sb);
            return {r, q};
         end
      endcase
   endfunction

   // Reference state: HI/LO, cycles of busy remaining, pending result
   logic [31:0] m_hi, m_lo;
   int          m_left;
   logic [63:0] m_pend;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_hi <= '0; m_lo <= '0; m_left <= 0; m_pend <= '0;
      end else if (m_left > 0) begin
         m_left <= m_left - 1;
         if (m_left == 1) begin
            m_hi <= m_pend[63:32];
            m_lo <= m_pend[31:0];
         end
      end else if (in_valid && alu_op == 3'b010 && is_mdu(funct)) begin
         if (funct == 6'h11) m_hi <= rs_val;
         if (funct == 6'h13) m_lo <= rs_val;
         if (funct inside {6'h18, 6'h19, 6'h1a, 6'h1b}) begin
            m_pend <= mdu_ref(funct, rs_val, rt_val);
            if ((funct == 6'h1a || funct == 6'h1b) &&
                (rt_val == 0 || (funct == 6'h1a && rs_val == 32'h80000000 && rt_val == 32'hFFFFFFFF)))
               m_left <= 1;
            else
               m_left <= W + 1;
         end
      end
   end

   // Per-cycle comparison against the reference
   always @(negedge clk) begin
      logic       mdu_in, exp_mf;
      logic [5:0] d;
      mdu_in = in_valid && alu_op == 3'b010 && is_mdu(funct);
      exp_mf = mdu_in && m_left == 0 && (funct == 6'h10 || funct == 6'h12);
      d = exp_dec(alu_op, funct);
      chk("operation", 64'(operation), 64'(d[5:2]));
      chk("jump", 64'(jump), 64'(d[1]));
      chk("link", 64'(link), 64'(d[0]));
      chk("busy", 64'(busy), 64'(m_left > 0));
      chk("stall", 64'(stall), 64'(mdu_in && m_left > 0));
      chk("mf_valid", 64'(mf_valid), 64'(exp_mf));
      if (exp_mf) chk("mf_result", 64'(mf_result), 64'(funct == 6'h10 ? m_hi : m_lo));
      chk("hi", 64'(hi), 64'(m_hi));
      chk("lo", 64'(lo), 64'(m_lo));
   end

   task automatic drive(input logic v, input logic [2:0] ao, input logic [5:0] f,
                        input logic [31:0] a, input logic [31:0] b);
      @(posedge clk);
      #1;
      in_valid = v; alu_op = ao; funct = f; rs_val = a; rt_val = b;
   endtask

   // Issue one mult/div and count busy cycles until it finishes
   task automatic run_mdu(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
      drive(1'b1, 3'b010, f, a, b);
      drive(1'b0, 3'b010, 6'h20, 0, 0);
      cyc = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!busy) break;
         cyc++;
      end
   endtask

   logic [5:0] fl [30] = '{6'h24, 6'h25, 6'h20, 6'h00, 6'h02, 6'h26, 6'h22, 6'h2a,
                            6'h21, 6'h23, 6'h2b, 6'h27, 6'h03, 6'h04, 6'h06, 6'h07,
                            6'h08, 6'h09, 6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19,
                            6'h1a, 6'h1b, 6'h3f, 6'h15, 6'h01, 6'h2c};

   initial begin
      int cyc, nst;
      logic got;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset hi", 64'(hi), 64'd0);
      chk("reset lo", 64'(lo), 64'd0);

      // Decode sweep, in_valid low so the MDU stays idle
      for (int ao = 0; ao < 8; ao++)
         for (int k = 0; k < 30; k++)
            drive(1'b0, 3'(ao), fl[k], 0, 0);

      drive(1'b0, 3'b010, 6'h09, 0, 0);
      @(negedge clk);
      chk("jalr op", 64'(operation), 64'h2);
      chk("jalr jump", 64'(jump), 64'd1);
      chk("jalr link", 64'(link), 64'd1);
      drive(1'b0, 3'b010, 6'h03, 0, 0);
      @(negedge clk);
      chk("sra op", 64'(operation), 64'hC);
      drive(1'b0, 3'b001, 6'h09, 0, 0);
      @(negedge clk);
      chk("aluop001 op", 64'(operation), 64'h9);
      chk("aluop001 jump", 64'(jump), 64'd0);
      drive(1'b0, 3'b010, 6'h3f, 0, 0);
      @(negedge clk);
      chk("default op", 64'(operation), 64'h2);
      chk("default jump", 64'(jump), 64'd0);

      run_mdu(6'h18, 32'hFFFFFFFD, 32'd5, cyc);
      chk("mult cycles", 64'(cyc), 64'd33);
      chk("mult hi", 64'(hi), 64'hFFFFFFFF);
      chk("mult lo", 64'(lo), 64'hFFFFFFF1);
      run_mdu(6'h19, 32'hFFFFFFFD, 32'd5, cyc);
      chk("multu cycles", 64'(cyc), 64'd33);
      chk("multu hi", 64'(hi), 64'h4);
      chk("multu lo", 64'(lo), 64'hFFFFFFF1);
      run_mdu(6'h1b, 32'd100, 32'd7, cyc);
      chk("divu hi", 64'(hi), 64'd2);
      chk("divu lo", 64'(lo), 64'd14);
      run_mdu(6'h1a, -32'sd7, 32'd2, cyc);
      chk("div hi", 64'(hi), 64'hFFFFFFFF);
      chk("div lo", 64'(lo), 64'hFFFFFFFD);
      run_mdu(6'h1a, 32'd5, 32'd0, cyc);
      chk("div0 cycles", 64'(cyc), 64'd1);
      chk("div0 hi", 64'(hi), 64'd5);
      chk("div0 lo", 64'(lo), 64'hFFFFFFFF);
      run_mdu(6'h1a, 32'h80000000, 32'hFFFFFFFF, cyc);
      chk("ovf cycles", 64'(cyc), 64'd1);
      chk("ovf hi", 64'(hi), 64'd0);
      chk("ovf lo", 64'(lo), 64'h80000000);

      // mflo issued while a mult is running: stalls, then returns the new LO
      drive(1'b1, 3'b010, 6'h18, 32'd6, 32'd7);
      drive(1'b0, 3'b010, 6'h20, 0, 0);
      drive(1'b0, 3'b010, 6'h20, 0, 0);
      drive(1'b1, 3'b010, 6'h12, 0, 0);
      nst = 0;
      got = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (mf_valid) begin
            got = 1'b1;
            break;
         end
         if (stall) nst++;
      end
      chk("mflo seen", 64'(got), 64'd1);
      chk("mflo stall cycles", 64'(nst), 64'd31);
      chk("mflo result", 64'(mf_result), 64'd42);

      drive(1'b1, 3'b010, 6'h13, 32'h12345678, 0);
      drive(1'b1, 3'b010, 6'h11, 32'h0000CAFE, 0);
      @(negedge clk);
      chk("mtlo lo", 64'(lo), 64'h12345678);
      drive(1'b0, 3'b010, 6'h20, 0, 0);
      @(negedge clk);
      chk("mthi hi", 64'(hi), 64'hCAFE);

      // Asynchronous reset in the middle of a divide
      drive(1'b1, 3'b010, 6'h1b, 32'd1000, 32'd3);
      drive(1'b0, 3'b010, 6'h20, 0, 0);
      repeat (9) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midreset busy", 64'(busy), 64'd0);
      chk("midreset hi", 64'(hi), 64'd0);
      chk("midreset lo", 64'(lo), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      run_mdu(6'h18, 32'h00010000, 32'h00010000, cyc);
      chk("post-reset cycles", 64'(cyc), 64'd33);
      chk("post-reset hi", 64'(hi), 64'd1);
      chk("post-reset lo", 64'(lo), 64'd0);

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
